mdu_iterative: RTL and testbench
================================

Name: mdu_iterative

Overview:
- Multi-cycle multiply/divide unit that owns the architectural HI/LO pair and executes MIPS32 MULT/MULTU/DIV/DIVU/MTHI/MTLO.
- Sits beside the combinational ALU in EX, parametrised in word width and multiplier pipeline depth.
- Core issues one op per start pulse and stalls on busy. Results are read from hi/lo, which are valid whenever busy is low.

Parameters:
- W, 32, operand/HI/LO width (any even value >= 8).
- MUL_STAGES, 2, multiply latency in cycles (>= 1).

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous active-high reset
- start  in  1  issue pulse; sampled only when busy=0
- mdu_op  in  4  0 NOP, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MTHI, 6 MTLO, 7 MADD, 8 MADDU, 9 MSUB, 10 MSUBU; others NOP
- op1  in  W  rs value (dividend / multiplicand / MTxx source)
- op2  in  W  rt value (divisor / multiplier)
- flush  in  1  abort in-flight op (exception/branch kill)
- busy  out  1  op in flight; core must stall MFHI/MFLO/next MDU op
- done  out  1  one-cycle pulse on the edge HI/LO are written by a MUL/DIV op
- hi  out  W  HI register
- lo  out  W  LO register
- div_by_zero  out  1  sticky until next start; set when DIV/DIVU has op2=0

Behaviour:
- Reset (async, any time incl. mid-op): state=IDLE, busy=0, done=0, div_by_zero=0, hi=0, lo=0, pipeline/iteration registers cleared.
- FSM states: IDLE, MUL, DIV, DIV_FIX.
  - IDLE: start with MULT/MULTU/MADD*/MSUB* -> MUL, counter=MUL_STAGES-1.
  - IDLE: start with DIV/DIVU -> DIV, counter=W-1.
  - IDLE: MTHI/MTLO write hi/lo at that edge, stay IDLE, no busy, no done.
  - IDLE: NOP or unsupported op ignored.
- Operands are latched at the start edge; op1/op2 may change afterwards.
- MUL:
  - 2W-bit product; signed (MULT/MADD/MSUB) or unsigned (MULTU/MADDU).
  - Counter decrements each cycle; at counter=0 write {hi,lo}=product, pulse done, -> IDLE.
  - busy is high for exactly MUL_STAGES cycles after the start edge; done fires on the MUL_STAGES-th edge after start.
- DIV:
  - Radix-2 restoring divide on magnitudes (signed ops take absolute values at start; MIN magnitude held in W+1 bits).
  - One quotient bit per cycle; after W iterations -> DIV_FIX.
- DIV_FIX (1 cycle):
  - Quotient negated if sign(op1) != sign(op2); remainder takes the sign of op1.
  - lo=quotient, hi=remainder, done pulse, -> IDLE.
  - Total latency W+1 cycles; busy high W+1 cycles.
- Divide by zero:
  - Detected at start; div_by_zero=1.
  - Result still follows the same W+1 timing, forced to lo={W{1'b1}}, hi=op1.
- Signed overflow: DIV with op1=MIN, op2=-1 gives lo=MIN, hi=0. No flag.
- start while busy=1: ignored, no state change.
- flush while busy: return to IDLE next edge, busy=0, no done, hi/lo unchanged.
- flush in IDLE has no effect; a start in the same cycle as flush in IDLE is dropped.
- flush on the same edge as the final write: flush wins, no write, no done.
- hi/lo hold their value while busy; only the completing edge or MTHI/MTLO changes them.

Optional Feature:
- Macro MDU_MADD_EN.
- Defined: MADD/MADDU compute {hi,lo} += product; MSUB/MSUBU compute {hi,lo} -= product.
  - 2W-bit wrap-around arithmetic.
  - {hi,lo} is sampled at completion, not at start. Same MUL_STAGES latency.
- Undefined: opcodes 7-10 are treated as NOP (no busy, no write) and the accumulate adder is not built.

Test Plan:
- Reset mid-DIV: start DIV 100/7, assert rst at cycle 5 -> busy=0, hi=lo=0 immediately, no done.
- MULT -3 x 5 (W=32, MUL_STAGES=2) -> busy 2 cycles; hi=0xFFFFFFFF, lo=0xFFFFFFF1, done on edge 2; MULTU 0xFFFFFFFF x 2 -> hi=1, lo=0xFFFFFFFE.
- DIV -7/2 -> lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1) after 33 cycles; DIVU 7/2 -> lo=3, hi=1; DIV 0x80000000/-1 -> lo=0x80000000, hi=0.
- DIVU 5/0 -> div_by_zero=1, lo=0xFFFFFFFF, hi=5 after 33 cycles; next start clears div_by_zero.
- Flush at DIV cycle 10 with hi=0x11, lo=0x22 preloaded via MTHI/MTLO -> busy drops next edge, hi/lo stay 0x11/0x22, no done; start during busy ignored.
- With MDU_MADD_EN, hi=0, lo=0xFFFFFFFF, MADDU 1x1 -> hi=1, lo=0; MSUB 2x3 from zero -> {hi,lo}=-6. Without the macro, same stimulus leaves hi/lo unchanged and busy=0.

Source files
------------

// File: rtl/mdu_iterative.sv
// mdu_iterative: multi-cycle MIPS32 multiply/divide unit owning HI/LO; `define MDU_MADD_EN builds MADD/MSUB accumulate
module mdu_iterative #(
  parameter int W = 32,
  parameter int MUL_STAGES = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [3:0]   mdu_op,
  input  logic [W-1:0] op1,
  input  logic [W-1:0] op2,
  input  logic         flush,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] hi,
  output logic [W-1:0] lo,
  output logic         div_by_zero
);
  typedef enum logic [1:0] {IDLE, MUL, DIV, DIV_FIX} state_t;
  localparam int CW = $clog2(W + MUL_STAGES + 1);
  state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [W-1:0] a_q, a_d, b_q, b_d, quo_q, quo_d, rem_q, rem_d, hi_q, hi_d, lo_q, lo_d;
  logic sgn_q, sgn_d, dz_q, dz_d, done_q, done_d;
  logic is_mul, is_div, sgn_op, ge;
  logic [W:0] t, dvs;
  logic [W-1:0] b_mag, quo_fix, rem_fix;
  logic [2*W-1:0] prod, mul_res;
`ifdef MDU_MADD_EN
  logic [1:0] acc_q, acc_d;
`endif
  function automatic logic [W-1:0] mag(input logic [W-1:0] v, input logic s);
    return (s && v[W-1]) ? -v : v;
  endfunction
  assign sgn_op = mdu_op inside {4'd1, 4'd3, 4'd7, 4'd9};
  assign is_div = mdu_op inside {4'd3, 4'd4};
`ifdef MDU_MADD_EN
  assign is_mul = mdu_op inside {4'd1, 4'd2, 4'd7, 4'd8, 4'd9, 4'd10};
  assign mul_res = acc_q == 2'd1 ? {hi_q, lo_q} + prod : acc_q == 2'd2 ? {hi_q, lo_q} - prod : prod;
`else
  assign is_mul = mdu_op inside {4'd1, 4'd2};
  assign mul_res = prod;
`endif
  // Latched operands are sign- or zero-extended so one 2W-bit multiply serves both flavours
  assign prod = {{W{sgn_q & a_q[W-1]}}, a_q} * {{W{sgn_q & b_q[W-1]}}, b_q};
  assign b_mag = mag(b_q, sgn_q);
  assign t = {rem_q, quo_q[W-1]};
  assign dvs = {1'b0, b_mag};
  assign ge = t >= dvs;
  assign quo_fix = (sgn_q & (a_q[W-1] ^ b_q[W-1])) ? -quo_q : quo_q;
  assign rem_fix = (sgn_q & a_q[W-1]) ? -rem_q : rem_q;
  assign busy = state_q != IDLE;
  assign done = done_q;
  assign hi = hi_q;
  assign lo = lo_q;
  assign div_by_zero = dz_q;
  // Next-state: issue in IDLE, count down MUL, shift-subtract DIV, sign-fix and write in DIV_FIX
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    a_d = a_q;
    b_d = b_q;
    sgn_d = sgn_q;
    quo_d = quo_q;
    rem_d = rem_q;
    dz_d = dz_q;
    done_d = 1'b0;
    hi_d = hi_q;
    lo_d = lo_q;
`ifdef MDU_MADD_EN
    acc_d = acc_q;
`endif
    if (state_q != IDLE && flush) begin
      state_d = IDLE;
    end else if (state_q == IDLE) begin
      if (start && !flush) begin
        state_d = is_mul ? MUL : is_div ? DIV : IDLE;
        cnt_d = is_mul ? CW'(MUL_STAGES - 1) : CW'(W - 1);
        a_d = op1;
        b_d = op2;
        sgn_d = sgn_op;
        quo_d = mag(op1, sgn_op);
        rem_d = '0;
        dz_d = is_div && op2 == '0;
        hi_d = mdu_op == 4'd5 ? op1 : hi_q;
        lo_d = mdu_op == 4'd6 ? op1 : lo_q;
`ifdef MDU_MADD_EN
        acc_d = mdu_op inside {4'd7, 4'd8} ? 2'd1 : mdu_op inside {4'd9, 4'd10} ? 2'd2 : 2'd0;
`endif
      end
    end else if (state_q == MUL) begin
      cnt_d = cnt_q - 1'b1;
      if (cnt_q == '0) begin
        {hi_d, lo_d} = mul_res;
        done_d = 1'b1;
        state_d = IDLE;
      end
    end else if (state_q == DIV) begin
      quo_d = {quo_q[W-2:0], ge};
      rem_d = ge ? W'(t - dvs) : t[W-1:0];
      cnt_d = cnt_q - 1'b1;
      state_d = cnt_q == '0 ? DIV_FIX : DIV;
    end else begin
      lo_d = dz_q ? '1 : quo_fix;
      hi_d = dz_q ? a_q : rem_fix;
      done_d = 1'b1;
      state_d = IDLE;
    end
  end
  // State and datapath registers, cleared asynchronously
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q <= '0;
      a_q <= '0;
      b_q <= '0;
      sgn_q <= 1'b0;
      quo_q <= '0;
      rem_q <= '0;
      dz_q <= 1'b0;
      done_q <= 1'b0;
      hi_q <= '0;
      lo_q <= '0;
`ifdef MDU_MADD_EN
      acc_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      a_q <= a_d;
      b_q <= b_d;
      sgn_q <= sgn_d;
      quo_q <= quo_d;
      rem_q <= rem_d;
      dz_q <= dz_d;
      done_q <= done_d;
      hi_q <= hi_d;
      lo_q <= lo_d;
`ifdef MDU_MADD_EN
      acc_q <= acc_d;
`endif
    end
  end
endmodule

// File: tb/tb_mdu_iterative.sv
// tb_mdu_iterative: directed and random MDU ops checked against an arithmetic reference model
module tb_mdu_iterative;
  localparam int W = 32;
  localparam int MS = 2;
`ifdef MDU_MADD_EN
  localparam bit MADD = 1'b1;
`else
  localparam bit MADD = 1'b0;
`endif
  logic clk = 1'b0, rst = 1'b1, start = 1'b0, flush = 1'b0;
  logic [3:0] mdu_op = '0;
  logic [W-1:0] op1 = '0, op2 = '0;
  logic busy, done, div_by_zero;
  logic [W-1:0] hi, lo;
  int checks = 0, failures = 0;
  logic [W-1:0] m_hi = '0, m_lo = '0;
  logic m_dz = 1'b0;
  int m_lat = 0;

  mdu_iterative #(.W(W), .MUL_STAGES(MS)) dut (
    .clk(clk), .rst(rst), .start(start), .mdu_op(mdu_op), .op1(op1), .op2(op2), .flush(flush),
    .busy(busy), .done(done), .hi(hi), .lo(lo), .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: architectural effect of one issued op, from plain integer arithmetic
  task automatic model(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    logic [2*W-1:0] p, acc;
    acc = {m_hi, m_lo};
    p = '0;
    m_lat = 0;
    m_dz = 1'b0;
    if (op inside {4'd1, 4'd7, 4'd9}) p = 64'(longint'($signed(a)) * longint'($signed(b)));
    else if (op inside {4'd2, 4'd8, 4'd10}) p = {32'b0, a} * {32'b0, b};
    if (op == 4'd1 || op == 4'd2) begin
      {m_hi, m_lo} = p;
      m_lat = MS;
    end else if (MADD && op inside {4'd7, 4'd8}) begin
      {m_hi, m_lo} = acc + p;
      m_lat = MS;
    end else if (MADD && op inside {4'd9, 4'd10}) begin
      {m_hi, m_lo} = acc - p;
      m_lat = MS;
    end else if (op == 4'd3 || op == 4'd4) begin
      m_lat = W + 1;
      m_dz = b == '0;
      if (b == '0) begin
        m_lo = '1;
        m_hi = a;
      end else if (op == 4'd3 && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
        m_lo = a;
        m_hi = '0;
      end else if (op == 4'd3) begin
        m_lo = W'($signed(a) / $signed(b));
        m_hi = W'($signed(a) % $signed(b));
      end else begin
        m_lo = a / b;
        m_hi = a % b;
      end
    end else if (op == 4'd5) begin
      m_hi = a;
    end else if (op == 4'd6) begin
      m_lo = a;
    end
  endtask

  task automatic run_op(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W-1:0] ph, pl;
    int cyc, dn, hold;
    ph = hi;
    pl = lo;
    cyc = 0;
    dn = 0;
    hold = 0;
    model(op, a, b);
    @(negedge clk);
    start = 1'b1;
    mdu_op = op;
    op1 = a;
    op2 = b;
    @(negedge clk);
    start = 1'b0;
    op1 = $urandom;
    op2 = $urandom;
    while (busy && cyc < 200) begin
      cyc++;
      if (done) dn++;
      if (hi !== ph || lo !== pl) hold++;
      @(negedge clk);
    end
    chk($sformatf("op%0d latency", op), 64'(cyc), 64'(m_lat));
    chk($sformatf("op%0d early_done", op), 64'(dn), 0);
    chk($sformatf("op%0d hold", op), 64'(hold), 0);
    chk($sformatf("op%0d done", op), 64'(done), 64'(m_lat != 0));
    chk($sformatf("op%0d hi", op), 64'(hi), 64'(m_hi));
    chk($sformatf("op%0d lo", op), 64'(lo), 64'(m_lo));
    chk($sformatf("op%0d dz", op), 64'(div_by_zero), 64'(m_dz));
    @(negedge clk);
    chk($sformatf("op%0d done_pulse", op), 64'(done), 0);
  endtask

  initial begin
    logic [3:0] ops [10] = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8, 4'd9, 4'd10};
    logic [W-1:0] ra, rb;
    repeat (2) @(negedge clk);
    chk("rst busy", 64'(busy), 0);
    chk("rst done", 64'(done), 0);
    chk("rst hi", 64'(hi), 0);
    chk("rst lo", 64'(lo), 0);
    chk("rst dz", 64'(div_by_zero), 0);
    rst = 1'b0;
    run_op(4'd1, -3, 5);
    chk("mult hi const", 64'(hi), 64'h0000_0000_FFFF_FFFF);
    chk("mult lo const", 64'(lo), 64'h0000_0000_FFFF_FFF1);
    run_op(4'd2, 32'hFFFF_FFFF, 2);
    chk("multu hi const", 64'(hi), 1);
    chk("multu lo const", 64'(lo), 64'h0000_0000_FFFF_FFFE);
    // Asynchronous reset in the middle of a divide
    @(negedge clk);
    start = 1'b1;
    mdu_op = 4'd3;
    op1 = 100;
    op2 = 7;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    chk("middiv busy", 64'(busy), 1);
    rst = 1'b1;
    #1;
    chk("midrst busy", 64'(busy), 0);
    chk("midrst hi", 64'(hi), 0);
    chk("midrst lo", 64'(lo), 0);
    chk("midrst done", 64'(done), 0);
    @(negedge clk);
    rst = 1'b0;
    m_hi = '0;
    m_lo = '0;
    m_dz = 1'b0;
    @(negedge clk);
    chk("postrst done", 64'(done), 0);
    chk("postrst busy", 64'(busy), 0);
    run_op(4'd3, -7, 2);
    chk("div lo const", 64'(lo), 64'h0000_0000_FFFF_FFFD);
    chk("div hi const", 64'(hi), 64'h0000_0000_FFFF_FFFF);
    run_op(4'd4, 7, 2);
    run_op(4'd3, 32'h8000_0000, 32'hFFFF_FFFF);
    chk("ovf lo const", 64'(lo), 64'h0000_0000_8000_0000);
    run_op(4'd4, 5, 0);
    chk("dz lo const", 64'(lo), 64'h0000_0000_FFFF_FFFF);
    chk("dz hi const", 64'(hi), 5);
    run_op(4'd1, 2, 3);
    run_op(4'd0, 9, 9);
    run_op(4'd12, 9, 9);
    // Flush mid-divide with a stray start while busy
    run_op(4'd5, 32'h11, 0);
    run_op(4'd6, 32'h22, 0);
    @(negedge clk);
    start = 1'b1;
    mdu_op = 4'd3;
    op1 = 1000;
    op2 = 3;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    start = 1'b1;
    mdu_op = 4'd1;
    op1 = 5;
    op2 = 5;
    @(negedge clk);
    start = 1'b0;
    chk("busy start ignored", 64'(busy), 1);
    repeat (4) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    chk("flush busy", 64'(busy), 0);
    chk("flush done", 64'(done), 0);
    chk("flush hi", 64'(hi), 64'h11);
    chk("flush lo", 64'(lo), 64'h22);
    @(negedge clk);
    chk("flush done later", 64'(done), 0);
    start = 1'b1;
    mdu_op = 4'd5;
    op1 = 32'h99;
    flush = 1'b1;
    @(negedge clk);
    start = 1'b0;
    flush = 1'b0;
    chk("idle flush drops start", 64'(hi), 64'h11);
    chk("idle flush busy", 64'(busy), 0);
    // Accumulate ops (NOPs when the feature is not built)
    run_op(4'd5, 0, 0);
    run_op(4'd6, 32'hFFFF_FFFF, 0);
    run_op(4'd8, 1, 1);
    run_op(4'd5, 0, 0);
    run_op(4'd6, 0, 0);
    run_op(4'd9, 2, 3);
    for (int i = 0; i < 30; i++) begin
      ra = $urandom;
      rb = $urandom_range(0, 3) == 0 ? W'($urandom_range(0, 9)) : W'($urandom);
      if ($urandom_range(0, 4) == 0) rb = '0;
      run_op(ops[$urandom_range(0, 9)], ra, rb);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
